// File: rtl/bitpos_pkg.sv
// Shared types for the set-bit position scheduler: data word, requester ID and
// the output-stage payload.
package bitpos_pkg;

  localparam int unsigned BP_WIDTH = 12;
  localparam int unsigned BP_N_REQ = 4;
  localparam int unsigned BP_ID_W  = $clog2(BP_N_REQ);

  typedef logic [BP_WIDTH-1:0] word_t;
  typedef logic [BP_ID_W-1:0]  id_t;

  typedef struct packed {
    id_t   id;
    word_t left;
    word_t right;
  } res_t;

endpackage

// File: rtl/bitpos_detect.sv
// Combinational left/right set-bit detector: one-hot of the most- and
// least-significant set bits; a zero word gives zero on both outputs.
module bitpos_detect
  import bitpos_pkg::*;
#(
  parameter int unsigned WIDTH = BP_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    left = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) left = WIDTH'(1) << i;
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign right = data & (~data + WIDTH'(1));

endmodule

// File: rtl/bitpos_rr_scheduler.sv
// Round-robin front end sharing one set-bit detector among N_REQ requesters,
// with a capture stage and a back-pressurable output stage.
module bitpos_rr_scheduler
  import bitpos_pkg::*;
#(
  parameter int unsigned WIDTH = BP_WIDTH,
  parameter int unsigned N_REQ = BP_N_REQ,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ID_W-1:0]        out_id_o,
  output logic [WIDTH-1:0]       data_o_left,
  output logic [WIDTH-1:0]       data_o_right
);

  logic [ID_W-1:0]  ptr;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [ID_W-1:0]  s1_id;
  logic             s2_valid;
  res_t             s2;

  logic             s2_free_c;
  logic             s1_free_c;
  logic             move_c;
  logic             hs_c;
  logic [N_REQ-1:0] grant_c;
  logic [ID_W-1:0]  gnt_id_c;
  logic [WIDTH-1:0] gnt_data_c;
  logic [ID_W-1:0]  ptr_nxt_c;
  logic [WIDTH-1:0] det_left;
  logic [WIDTH-1:0] det_right;

  assign s2_free_c = !s2_valid || out_ready_i;
  assign s1_free_c = !s1_valid || s2_free_c;
  assign move_c    = s1_valid && s2_free_c;

  // Rotating-priority search starting at ptr; held off while reset is asserted.
  always_comb begin
    logic          found;
    logic [ID_W:0] sum;
    logic [ID_W-1:0] idx;
    grant_c  = '0;
    gnt_id_c = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    if (arstn_i && s1_free_c) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        sum = {1'b0, ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
        idx = sum[ID_W-1:0];
        if (!found && req_valid_i[idx]) begin
          found    = 1'b1;
          gnt_id_c = idx;
          grant_c  = N_REQ'(1) << idx;
        end
      end
    end
  end

  always_comb begin
    gnt_data_c = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant_c[j]) gnt_data_c = req_data_i[j*WIDTH +: WIDTH];
    end
  end

  assign hs_c      = |grant_c;
  assign ptr_nxt_c = (gnt_id_c == ID_W'(N_REQ-1)) ? '0 : gnt_id_c + ID_W'(1);

  bitpos_detect #(.WIDTH(WIDTH)) u_detect (
    .data  (s1_data),
    .left  (det_left),
    .right (det_right)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2       <= '0;
    end else begin
      if (hs_c) begin
        s1_data <= gnt_data_c;
        s1_id   <= gnt_id_c;
        ptr     <= ptr_nxt_c;
      end
      // A new grant refills S1 in the same cycle it drains.
      if (hs_c)        s1_valid <= 1'b1;
      else if (move_c) s1_valid <= 1'b0;
      if (move_c) begin
        s2.id    <= s1_id;
        s2.left  <= det_left;
        s2.right <= det_right;
      end
      s2_valid <= move_c || (s2_valid && !out_ready_i);
    end
  end

  assign req_ready_o  = grant_c;
  assign out_valid_o  = s2_valid;
  assign out_id_o     = s2.id;
  assign data_o_left  = s2.left;
  assign data_o_right = s2.right;

endmodule
